// File: rtl/hamming_pkg.sv
// hamming_pkg: flag encodings, codeword bit positions, status-byte packing and beat states shared by the decoder stages
package hamming_pkg;
  localparam logic [1:0] FLAG_NONE = 2'd0;
  localparam logic [1:0] FLAG_SEC  = 2'd1;
  localparam logic [1:0] FLAG_DED  = 2'd2;
  localparam int POS_C0    = 0;
  localparam int POS_C1    = 1;
  localparam int POS_D0    = 2;
  localparam int POS_C2    = 3;
  localparam int POS_D1    = 4;
  localparam int POS_D2    = 5;
  localparam int POS_D3    = 6;
  localparam int POS_C_ALL = 7;
  typedef enum logic {BEAT0, BEAT1} beat_e;
  function automatic logic [7:0] status_byte(input logic [2:0] loc, input logic [1:0] flag);
    return {3'b000, loc, flag};
  endfunction
endpackage

// File: rtl/hamming_result_fifo.sv
// hamming_result_fifo: synchronous DEPTH x W FIFO; push while full and pop while empty are ignored
module hamming_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    empty   = cnt_q == '0;
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head    = mem_q[rd_q];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/hamming_result_buffer.sv
// hamming_result_buffer: buffers decoder results and emits codeword/status byte pairs.
// Define HAMMING_RESULT_CNT_EN to build the saturating SEC/DED counters.
module hamming_result_buffer
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       code_in,
  input  logic [3:0]       syndrome_in,
  input  logic [1:0]       error_flag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count,
  output logic             overflow,
  input  logic             clr_counts
);
  logic        full, empty, pop;
  logic [12:0] head;
  beat_e       beat_q, beat_d;
  logic        overflow_q, overflow_d;
  logic        unused_syn;
  assign unused_syn = syndrome_in[3];
  hamming_result_fifo #(.DEPTH(DEPTH), .W(13)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (in_valid),
    .pop  (pop),
    .din  ({code_in, syndrome_in[2:0], error_flag_in}),
    .full (full),
    .empty(empty),
    .head (head)
  );
  always_comb begin
    in_ready   = !full;
    out_valid  = !empty;
    pop        = out_valid && out_ready && beat_q == BEAT1;
    beat_d     = (out_valid && out_ready) ? (beat_q == BEAT0 ? BEAT1 : BEAT0) : beat_q;
    out_byte   = !out_valid ? 8'h00 : beat_q == BEAT0 ? head[12:5] : status_byte(head[4:2], head[1:0]);
    out_last   = out_valid && beat_q == BEAT1;
    overflow_d = !clr_counts && (overflow_q || (in_valid && !in_ready));
    overflow   = overflow_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_q     <= BEAT0;
      overflow_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
`ifdef HAMMING_RESULT_CNT_EN
  logic [CNT_W-1:0] sec_q, sec_d, ded_q, ded_d;
  logic             push_acc;
  always_comb begin
    push_acc = in_valid && in_ready;
    sec_d = clr_counts ? '0 : (push_acc && error_flag_in == FLAG_SEC && sec_q != '1) ? sec_q + CNT_W'(1) : sec_q;
    ded_d = clr_counts ? '0 : (push_acc && error_flag_in == FLAG_DED && ded_q != '1) ? ded_q + CNT_W'(1) : ded_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sec_q <= '0;
      ded_q <= '0;
    end else begin
      sec_q <= sec_d;
      ded_q <= ded_d;
    end
  assign sec_count = sec_q;
  assign ded_count = ded_q;
`else
  assign sec_count = '0;
  assign ded_count = '0;
`endif
endmodule

// File: tb/tb_hamming_result_buffer.sv
// tb_hamming_result_buffer: random and directed stimulus checked against a byte-stream reference model
module tb_hamming_result_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef HAMMING_RESULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic             clk = 0, rst_n = 0;
  logic             in_valid = 0, out_ready = 0, clr_counts = 0;
  logic [7:0]       code_in = 0;
  logic [3:0]       syndrome_in = 0;
  logic [1:0]       error_flag_in = 0;
  logic             in_ready, out_valid, out_last, overflow;
  logic [7:0]       out_byte;
  logic [CNT_W-1:0] sec_count, ded_count;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  int m_sec = 0, m_ded = 0, m_f1 = 0;
  bit m_ovf = 0;

  hamming_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .syndrome_in(syndrome_in), .error_flag_in(error_flag_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .sec_count(sec_count), .ded_count(ded_count), .overflow(overflow), .clr_counts(clr_counts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = q.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_byte", 32'(out_byte), ev ? 32'(q[0]) : 32'h0);
    chk("out_last", 32'(out_last), 32'(ev && (q.size() % 2 == 1)));
    chk("in_ready", 32'(in_ready), 32'((q.size() + 1) / 2 < DEPTH));
    chk("sec_count", 32'(sec_count), CNT_EN ? 32'(m_sec) : 32'h0);
    chk("ded_count", 32'(ded_count), CNT_EN ? 32'(m_ded) : 32'h0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic iv, input logic [7:0] code, input logic [3:0] syn,
                      input logic [1:0] flag, input logic ordy, input logic clr);
    bit acc, hs;
    @(negedge clk);
    check_outputs();
    in_valid = iv; code_in = code; syndrome_in = syn; error_flag_in = flag;
    out_ready = ordy; clr_counts = clr;
    acc = iv && ((q.size() + 1) / 2 < DEPTH);
    hs  = q.size() > 0 && ordy;
    @(posedge clk);
    if (hs) void'(q.pop_front());
    if (acc) begin
      q.push_back(code);
      q.push_back(8'((syn % 8) * 4 + flag));
      if (flag == 1) m_f1++;
    end
    if (clr) begin
      m_sec = 0; m_ded = 0; m_ovf = 0;
    end else begin
      if (iv && !acc) m_ovf = 1;
      if (acc && flag == 1 && m_sec < MAXC) m_sec++;
      if (acc && flag == 2 && m_ded < MAXC) m_ded++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 4'h0, 2'd0, 1, 0);
  endtask

  initial begin
    #1 chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(1, 8'hD2, 4'h0, 2'd0, 1, 0);
    idle(3);
    step(1, 8'h5A, 4'hD, 2'd1, 1, 0);
    step(1, 8'h3C, 4'h3, 2'd2, 1, 0);
    idle(5);
    for (int i = 0; i <= DEPTH; i++) step(1, 8'(8'h10 + i), 4'(i), 2'(i % 3), 0, 0);
    #1 chk("ovf_set", 32'(overflow), 1);
    chk("full_ready", 32'(in_ready), 0);
    idle(2 * DEPTH + 2);
    for (int i = 0; i < 1000 && m_f1 < 300; i++)
      step(1, 8'($urandom), 4'($urandom), 2'd1, 1, 0);
    #1 chk("sec_sat", 32'(sec_count), CNT_EN ? MAXC : 0);
    step(1, 8'h77, 4'h1, 2'd1, 1, 1);
    #1 chk("clr_sec", 32'(sec_count), 0);
    chk("clr_ovf", 32'(overflow), 0);
    idle(2 * DEPTH + 2);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), 4'($urandom), 2'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    idle(2 * DEPTH + 2);
    step(1, 8'hA5, 4'h2, 2'd1, 0, 0);
    step(0, 8'h00, 4'h0, 2'd0, 1, 0);
    @(negedge clk);
    chk("pre_rst_last", 32'(out_last), 1);
    rst_n = 0;
    #1 chk("arst_valid", 32'(out_valid), 0);
    chk("arst_byte", 32'(out_byte), 0);
    chk("arst_last", 32'(out_last), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_sec", 32'(sec_count), 0);
    chk("arst_ovf", 32'(overflow), 0);
    q.delete(); m_sec = 0; m_ded = 0; m_ovf = 0;
    @(negedge clk);
    rst_n = 1;
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
